mem_port_arbiter: RTL and testbench

Sequencer/arbiter that shares one single-port unified memory between the core's instruction-fetch port and its data (load/store) port. Sits between the datapath/fetch logic and the memory: accepts one request per requester over a req/ready handshake, picks a winner with data-priority plus starvation protection, drives the memory for one access, waits the configured memory latency, and returns read data to the winner.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_pick.sv | 24 ++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  // Width of a counter that runs 0 .. lat-1 (never narrower than one bit).
  function automatic int unsigned lat_cnt_w(input int unsigned lat);
    return (lat <= 1) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner selection: data has priority unless fetch has waited MAX_DATA_BURST data grants.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned CNT_W          = 3
) (
  input  logic             i_fetch_req,
  input  logic             i_data_req,
  input  logic [CNT_W-1:0] i_burst_cnt,
  output logic             o_gnt_c,
  output logic             o_gnt_valid_c
);

  logic w_starve;

  always_comb begin
    w_starve      = i_fetch_req && (i_burst_cnt == CNT_W'(MAX_DATA_BURST));
    o_gnt_valid_c = i_fetch_req | i_data_req;
    o_gnt_c       = GNT_I;
    if (i_data_req && !w_starve) o_gnt_c = GNT_D;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports:
// grant, one-cycle access strobe, fixed-latency wait, one-cycle response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(MAX_DATA_BURST + 1);
  localparam int unsigned LAT_W  = lat_cnt_w(MEM_LATENCY);

  state_t             r_state;
  gnt_t               r_gnt;
  logic               r_is_read;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic               r_i_ready;
  logic               r_d_ready;
  logic [DATA_W-1:0]  r_i_rdata;
  logic [DATA_W-1:0]  r_d_rdata;
  logic               r_mem_en;
  logic [MASK_W-1:0]  r_mem_wmask;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               w_gnt;
  logic               w_gnt_valid;

  arb_pick #(
    .MAX_DATA_BURST(MAX_DATA_BURST),
    .CNT_W         (CNT_W)
  ) u_pick (
    .i_fetch_req  (i_req),
    .i_data_req   (d_req),
    .i_burst_cnt  (r_burst_cnt),
    .o_gnt_c      (w_gnt),
    .o_gnt_valid_c(w_gnt_valid)
  );

  // Memory-side registers double as the request latch: they only carry
  // the access during the single ACCESS cycle and are zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_gnt       <= GNT_I;
      r_is_read   <= 1'b0;
      r_burst_cnt <= '0;
      r_lat_cnt   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_wmask <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_wmask <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!i_req) r_burst_cnt <= '0;
          if (w_gnt_valid) begin
            r_gnt    <= gnt_t'(w_gnt);
            r_state  <= ST_ACCESS;
            r_mem_en <= 1'b1;
            if (w_gnt == GNT_D) begin
              r_mem_addr  <= d_addr;
              r_mem_wmask <= d_wmask;
              r_mem_wdata <= d_wdata;
              r_is_read   <= (d_wmask == '0);
              if (i_req && (r_burst_cnt != CNT_W'(MAX_DATA_BURST)))
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end else begin
              r_mem_addr  <= i_addr;
              r_is_read   <= 1'b1;
              r_burst_cnt <= '0;
            end
          end
        end
        ST_ACCESS: begin
          r_lat_cnt <= '0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_lat_cnt == LAT_W'(MEM_LATENCY - 1)) begin
            r_state <= ST_RESP;
            if (r_gnt == GNT_D) begin
              r_d_ready <= 1'b1;
              r_d_rdata <= r_is_read ? mem_rdata : '0;
            end else begin
              r_i_ready <= 1'b1;
              r_i_rdata <= mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign i_ready   = r_i_ready;
  assign i_rdata   = r_i_rdata;
  assign d_ready   = r_d_ready;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_wmask = r_mem_wmask;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at latency 1 and one at latency 3, each with a byte-masked memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Instance A: MEM_LATENCY=1
  logic        a_i_req, a_i_ready, a_d_req, a_d_ready, a_mem_en;
  logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_d_wmask, a_mem_wmask;
  logic [31:0] mem_a [0:255];

  // Instance B: MEM_LATENCY=3
  logic        b_i_req, b_i_ready, b_d_req, b_d_ready, b_mem_en;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_d_wmask, b_mem_wmask;
  logic [31:0] mem_b [0:255];
  logic [31:0] b_p0, b_p1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_DATA_BURST(4)) u_a (
    .clk(clk), .reset(reset),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ready(a_i_ready), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_wmask(a_d_wmask), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ready(a_d_ready), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_wmask(a_mem_wmask), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .MAX_DATA_BURST(4)) u_b (
    .clk(clk), .reset(reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_wmask(b_d_wmask), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_wmask(b_mem_wmask), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory A: read data visible the cycle after the strobe.
  always @(posedge clk) begin
    if (a_mem_en) begin
      a_mem_rdata <= mem_a[a_mem_addr[9:2]];
      for (int k = 0; k < 4; k++)
        if (a_mem_wmask[k]) mem_a[a_mem_addr[9:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
    end
  end

  // Memory B: read data visible three cycles after the strobe.
  always @(posedge clk) begin
    if (b_mem_en) begin
      b_p0 <= mem_b[b_mem_addr[9:2]];
      for (int k = 0; k < 4; k++)
        if (b_mem_wmask[k]) mem_b[b_mem_addr[9:2]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
    end
    b_p1        <= b_p0;
    b_mem_rdata <= b_p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a ready on instance A; got_d=1 for data, ok=0 on timeout.
  task automatic wait_a_ready(input int max_cyc, output logic got_d, output logic ok);
    ok    = 1'b0;
    got_d = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      tick();
      chk("ready_exclusive", 32'(a_i_ready & a_d_ready), 32'd0);
      if (a_i_ready || a_d_ready) begin
        got_d = a_d_ready;
        ok    = 1'b1;
        break;
      end
    end
  endtask

  logic       got_d;
  logic       ok;
  logic [5:0] exp_order;

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 32'd0;
      mem_b[k] = 32'd0;
    end
    mem_a[4]  = 32'h0050_0093;
    mem_b[8]  = 32'hCAFE_F00D;
    mem_b[9]  = 32'h1122_3344;
    a_mem_rdata = 32'd0;
    b_p0 = 32'd0; b_p1 = 32'd0; b_mem_rdata = 32'd0;
    a_i_req = 0; a_i_addr = 0; a_d_req = 0; a_d_wmask = 0; a_d_addr = 0; a_d_wdata = 0;
    b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_wmask = 0; b_d_addr = 0; b_d_wdata = 0;
    reset = 1'b0;
    #12;
    chk("rst_i_ready", 32'(a_i_ready), 32'd0);
    chk("rst_d_ready", 32'(a_d_ready), 32'd0);
    chk("rst_mem_en", 32'(a_mem_en), 32'd0);
    chk("rst_mem_addr", a_mem_addr, 32'd0);
    chk("rst_i_rdata", a_i_rdata, 32'd0);
    chk("rst_b_mem_wmask", 32'(b_mem_wmask), 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    tick();

    // Fetch only
    a_i_req = 1; a_i_addr = 32'h10;
    tick();
    chk("fetch_mem_en", 32'(a_mem_en), 32'd1);
    chk("fetch_mem_addr", a_mem_addr, 32'h10);
    chk("fetch_mem_wmask", 32'(a_mem_wmask), 32'd0);
    tick();
    chk("fetch_mem_en_drop", 32'(a_mem_en), 32'd0);
    chk("fetch_mem_addr_zero", a_mem_addr, 32'd0);
    tick();
    chk("fetch_i_ready", 32'(a_i_ready), 32'd1);
    chk("fetch_i_rdata", a_i_rdata, 32'h0050_0093);
    chk("fetch_d_ready", 32'(a_d_ready), 32'd0);
    a_i_req = 0;
    tick();
    chk("fetch_i_ready_pulse", 32'(a_i_ready), 32'd0);

    // Store then load
    a_d_req = 1; a_d_wmask = 4'hF; a_d_addr = 32'h100; a_d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("store_mem_en", 32'(a_mem_en), 32'd1);
    chk("store_mem_wmask", 32'(a_mem_wmask), 32'hF);
    chk("store_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    tick();
    tick();
    chk("store_d_ready", 32'(a_d_ready), 32'd1);
    chk("store_d_rdata", a_d_rdata, 32'd0);
    a_d_wmask = 4'h0; a_d_wdata = 32'd0;
    tick();
    chk("store_d_ready_pulse", 32'(a_d_ready), 32'd0);
    tick();
    chk("load_mem_en", 32'(a_mem_en), 32'd1);
    chk("load_mem_wmask", 32'(a_mem_wmask), 32'd0);
    chk("load_mem_addr", a_mem_addr, 32'h100);
    tick();
    tick();
    chk("load_d_ready", 32'(a_d_ready), 32'd1);
    chk("load_d_rdata", a_d_rdata, 32'hDEAD_BEEF);
    a_d_req = 0;
    tick();

    // Simultaneous requests: data first, then fetch
    a_i_req = 1; a_i_addr = 32'h10; a_d_req = 1; a_d_addr = 32'h100;
    tick();
    chk("sim_first_addr", a_mem_addr, 32'h100);
    tick();
    tick();
    chk("sim_d_ready", 32'(a_d_ready), 32'd1);
    chk("sim_i_ready_low", 32'(a_i_ready), 32'd0);
    a_d_req = 0;
    tick();
    chk("sim_idle_no_ready", 32'(a_i_ready | a_d_ready), 32'd0);
    tick();
    chk("sim_fetch_mem_en", 32'(a_mem_en), 32'd1);
    chk("sim_fetch_addr", a_mem_addr, 32'h10);
    tick();
    tick();
    chk("sim_i_ready", 32'(a_i_ready), 32'd1);
    chk("sim_i_rdata", a_i_rdata, 32'h0050_0093);
    a_i_req = 0;
    tick();

    // Starvation protection: D,D,D,D,I,D
    exp_order = 6'b101111;
    a_i_req = 1; a_d_req = 1;
    for (int n = 0; n < 6; n++) begin
      wait_a_ready(12, got_d, ok);
      chk("grant_wait", 32'(ok), 32'd1);
      chk("grant_order", 32'(got_d), 32'(exp_order[n]));
      if (n == 3) chk("burst_cnt_sat", 32'(u_a.r_burst_cnt), 32'd4);
      if (!got_d) begin
        chk("burst_cnt_clear", 32'(u_a.r_burst_cnt), 32'd0);
        a_i_req = 0;
      end
    end
    a_d_req = 0;
    tick();

    // Latency 3 read on instance B
    b_d_req = 1; b_d_wmask = 4'h0; b_d_addr = 32'h20;
    tick();
    chk("l3_mem_en", 32'(b_mem_en), 32'd1);
    chk("l3_mem_addr", b_mem_addr, 32'h20);
    tick();
    tick();
    tick();
    chk("l3_not_ready_c4", 32'(b_d_ready), 32'd0);
    tick();
    chk("l3_d_ready_c5", 32'(b_d_ready), 32'd1);
    chk("l3_d_rdata", b_d_rdata, 32'hCAFE_F00D);
    b_d_req = 0;
    tick();

    // Reset during WAIT drops the fetch
    b_i_req = 1; b_i_addr = 32'h24;
    tick();
    chk("rstw_mem_en", 32'(b_mem_en), 32'd1);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("rstw_d_rdata", b_d_rdata, 32'd0);
    chk("rstw_mem_en", 32'(b_mem_en), 32'd0);
    chk("rstw_i_ready", 32'(b_i_ready), 32'd0);
    b_i_req = 0;
    @(negedge clk) reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("rstw_no_ready", 32'(b_i_ready | b_d_ready), 32'd0);
    end
    b_d_req = 1; b_d_addr = 32'h20;
    tick();
    chk("post_rst_mem_en", 32'(b_mem_en), 32'd1);
    tick();
    tick();
    tick();
    tick();
    chk("post_rst_d_ready", 32'(b_d_ready), 32'd1);
    chk("post_rst_d_rdata", b_d_rdata, 32'hCAFE_F00D);
    chk("post_rst_i_ready", 32'(b_i_ready), 32'd0);
    b_d_req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
